clock_divider_mc: RTL and testbench

Multi-channel, AXI4-Lite-programmable clock divider. It is the parametrised successor to the single-channel ClockDivider IP.
- Generates NUM_CH independent divided clock outputs from ACLK, each with its own period, high time (duty) and enable.
- Period and high-time changes are glitch-free: new values take effect only at a period boundary.
- A sync register lets software phase-align any subset of channels.
- Sits on the PS/PL AXI interconnect as a slave. Its outputs feed fabric logic as divided clocks or one-cycle ticks.

---
 rtl/clock_divider_mc_if.sv | 34 +++
 rtl/clock_divider_mc.sv | 207 ++++++++++++++++++++
 tb/tb_clock_divider_mc.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_divider_mc_if.sv
// AXI4-Lite slave bus bundle for the multi-channel clock divider.
// Signal names mirror the S_AXI_* names of the register interface.
interface clock_divider_mc_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/clock_divider_mc.sv
// Multi-channel AXI4-Lite programmable clock divider.
// Each channel keeps AXI-visible (programmed) PERIOD/HIGH values and a set of
// active values used by its counter; active values only change at a period
// wrap, on a SYNC restart, or while the channel is stopped, so no runt pulses.
// The bus interface parameters must match C_S_AXI_ADDR_WIDTH/DATA_WIDTH.
module clock_divider_mc #(
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  clock_divider_mc_if.slave s_axi,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int WW = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [WW-1:0] A_CTRL   = WW'(0);
  localparam logic [WW-1:0] A_STATUS = WW'(1);
  localparam logic [WW-1:0] A_SYNC   = WW'(2);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic                 wr_ready_q;
  logic                 bvalid_q;
  logic                 arready_q;
  logic                 rvalid_q;
  logic [DW-1:0]        rdata_q;
  logic [DW-1:0]        rdata_d;
  logic [NUM_CH-1:0]    ctrl_q;
  logic [NUM_CH-1:0]    sync_q;
  logic [NUM_CH-1:0]    status;
  logic [CNT_WIDTH-1:0] per_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] high_q [NUM_CH];
  logic [NUM_CH-1:0]    wr_per_hit;
  logic [NUM_CH-1:0]    wr_high_hit;
  logic [NUM_CH-1:0]    rd_per_hit;
  logic [NUM_CH-1:0]    rd_high_hit;
  logic [WW-1:0]        wr_word;
  logic [WW-1:0]        rd_word;
  logic [DW-1:0]        wmask;
  logic                 wr_en;
  logic                 rd_en;
  logic                 unused_bits;

  // Byte lanes are word-aligned; the two low address bits carry no meaning.
  assign wr_word = s_axi.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word = s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_en   = wr_ready_q & s_axi.AWVALID & s_axi.WVALID;
  assign rd_en   = arready_q & s_axi.ARVALID;

  assign s_axi.AWREADY = wr_ready_q;
  assign s_axi.WREADY  = wr_ready_q;
  assign s_axi.BRESP   = 2'b00;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = 2'b00;
  assign s_axi.RVALID  = rvalid_q;

  // Register bits that can never hold data above the counter width.
  assign unused_bits = ^{s_axi.AWADDR[1:0], s_axi.ARADDR[1:0],
                         s_axi.WDATA[DW-1:CNT_WIDTH], wmask[DW-1:CNT_WIDTH]};

  genvar gi;

  // Expand WSTRB into a per-bit write mask.
  for (gi = 0; gi < DW / 8; gi++) begin : g_wmask
    assign wmask[8*gi +: 8] = {8{s_axi.WSTRB[gi]}};
  end

  // Per-channel address decode: PERIOD_i at word 8+2i, HIGH_i at word 9+2i.
  for (gi = 0; gi < NUM_CH; gi++) begin : g_dec
    assign wr_per_hit[gi]  = (wr_word == WW'(8 + 2 * gi));
    assign wr_high_hit[gi] = (wr_word == WW'(9 + 2 * gi));
    assign rd_per_hit[gi]  = (rd_word == WW'(8 + 2 * gi));
    assign rd_high_hit[gi] = (rd_word == WW'(9 + 2 * gi));
  end

  // AXI handshakes: one-cycle ready pulses, responses held until accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_ready_q <= !wr_ready_q && s_axi.AWVALID && s_axi.WVALID && !bvalid_q;
      if (wr_en) begin
        bvalid_q <= 1'b1;
      end else if (s_axi.BREADY) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= !arready_q && s_axi.ARVALID && !rvalid_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (s_axi.RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Read mux; sampled on the same edge as any write, so reads see old values.
  always_comb begin
    rdata_d = '0;
    if (rd_word == A_CTRL) begin
      rdata_d = DW'(ctrl_q);
    end else if (rd_word == A_STATUS) begin
      rdata_d = DW'(status);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_per_hit[i]) rdata_d = DW'(per_q[i]);
      if (rd_high_hit[i]) rdata_d = DW'(high_q[i]);
    end
  end

  // Programmed registers with byte-strobe merge; SYNC is a one-cycle pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q <= '0;
      sync_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        per_q[i]  <= ONE;
        high_q[i] <= ONE;
      end
    end else begin
      sync_q <= '0;
      if (wr_en) begin
        if (wr_word == A_CTRL) begin
          ctrl_q <= (ctrl_q & ~wmask[NUM_CH-1:0]) | (s_axi.WDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
        end
        if (wr_word == A_SYNC) begin
          sync_q <= s_axi.WDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0];
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_per_hit[i]) begin
            per_q[i] <= (per_q[i] & ~wmask[CNT_WIDTH-1:0]) | (s_axi.WDATA[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
          end
          if (wr_high_hit[i]) begin
            high_q[i] <= (high_q[i] & ~wmask[CNT_WIDTH-1:0]) | (s_axi.WDATA[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
          end
        end
      end
    end
  end

  // Divider channels.
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] act_per_q;
    logic [CNT_WIDTH-1:0] act_per_d;
    logic [CNT_WIDTH-1:0] act_high_q;
    logic [CNT_WIDTH-1:0] act_high_d;
    logic                 run_q;
    logic                 clk_q;
    logic                 tick_q;
    logic                 restart;
    logic                 wrap;

    // A channel restarts on its first enabled cycle or on SYNC while enabled.
    assign restart = !run_q || sync_q[gi];
    assign wrap    = (cnt_q == act_per_q);

    // Next counter value and the shadow-to-active reload at period boundaries.
    always_comb begin
      act_per_d  = act_per_q;
      act_high_d = act_high_q;
      cnt_d      = '0;
      if (!ctrl_q[gi] || restart || wrap) begin
        act_per_d  = per_q[gi];
        act_high_d = high_q[gi];
      end
      if (ctrl_q[gi] && !restart && !wrap) begin
        cnt_d = cnt_q + ONE;
      end
    end

    // Counter, active values and registered clk_out/tick/status.
    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        cnt_q      <= '0;
        act_per_q  <= ONE;
        act_high_q <= ONE;
        run_q      <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_per_q  <= act_per_d;
        act_high_q <= act_high_d;
        run_q      <= ctrl_q[gi];
        clk_q      <= ctrl_q[gi] && (cnt_d < act_high_d);
        tick_q     <= ctrl_q[gi] && (cnt_d == '0);
      end
    end

    assign clk_out[gi] = clk_q;
    assign tick[gi]    = tick_q;
    assign status[gi]  = run_q;
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Scoreboard bench for clock_divider_mc: stimulus pushes expected per-cycle
// output/handshake values and expected read data; a negedge monitor pops and
// compares them.
module tb_clock_divider_mc;

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic [3:0] clk_out;
  logic [3:0] tick;

  clock_divider_mc_if #(.ADDR_W(7), .DATA_W(32)) s_axi ();

  clock_divider_mc #(
    .NUM_CH(4),
    .CNT_WIDTH(16),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(7)
  ) dut (
    .ACLK(ACLK),
    .ARESETN(ARESETN),
    .s_axi(s_axi),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 ACLK = ~ACLK;

  // kind 0: a = clk_out, b = tick; kind 1: a = {0, AWREADY, WREADY, BVALID}
  typedef struct {
    string      name;
    int         kind;
    logic [3:0] a;
    logic [3:0] b;
  } cyc_t;

  typedef struct {
    string       name;
    logic [31:0] data;
  } rd_t;

  cyc_t cyc_q[$];
  rd_t  rd_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: one expected entry per cycle, plus every read response.
  always @(negedge ACLK) begin
    if (cyc_q.size() > 0) begin
      cyc_t       e;
      logic [3:0] hs;
      e  = cyc_q.pop_front();
      hs = {1'b0, s_axi.AWREADY, s_axi.WREADY, s_axi.BVALID};
      total++;
      if (e.kind == 0) begin
        if (clk_out !== e.a || tick !== e.b) begin
          bad++;
          $display("FAIL %s: clk_out=%b tick=%b, expected clk_out=%b tick=%b",
                   e.name, clk_out, tick, e.a, e.b);
        end
      end else begin
        if (hs !== e.a) begin
          bad++;
          $display("FAIL %s: awready/wready/bvalid=%b, expected %b",
                   e.name, hs[2:0], e.a[2:0]);
        end
      end
    end
    if (s_axi.RVALID && s_axi.RREADY) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rvalid: rdata=%h, expected no response", s_axi.RDATA);
      end else begin
        rd_t r;
        r = rd_q.pop_front();
        if (s_axi.RDATA !== r.data) begin
          bad++;
          $display("FAIL %s: rdata=%h, expected %h", r.name, s_axi.RDATA, r.data);
        end else begin
          $display("rd %s data=%h ok", r.name, s_axi.RDATA);
        end
      end
    end
  end

  function automatic void push_cyc(input string nm, input int kind,
                                   input logic [3:0] a, input logic [3:0] b);
    cyc_t e;
    e.name = nm;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    cyc_q.push_back(e);
  endfunction

  // Expected waveform: cycle k of a period (per+1) is high while k < high.
  function automatic void push_wave(input string nm, input int n, input int per,
                                    input int high, input logic [3:0] mask);
    for (int k = 0; k < n; k++) begin
      int j;
      j = k % (per + 1);
      push_cyc(nm, 0, (j < high) ? mask : 4'h0, (j == 0) ? mask : 4'h0);
    end
  endfunction

  task automatic timeout_fail(input string what);
    bad++;
    total++;
    $display("FAIL timeout_%s: no response within budget, expected one", what);
  endtask

  // Wait until every pushed expectation is consumed; returns 1 time unit after a posedge.
  task automatic drain();
    int n;
    n = 0;
    do begin
      @(posedge ACLK);
      n++;
    end while ((cyc_q.size() > 0 || rd_q.size() > 0) && n < 400);
    if (cyc_q.size() > 0 || rd_q.size() > 0) begin
      timeout_fail("drain");
      cyc_q.delete();
      rd_q.delete();
    end
    #1;
  endtask

  // Full write transaction; returns 1 time unit after the edge following the handshake.
  task automatic axi_write(input logic [6:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge ACLK);
    #1;
    s_axi.AWADDR  = addr;
    s_axi.AWVALID = 1'b1;
    s_axi.WDATA   = data;
    s_axi.WSTRB   = strb;
    s_axi.WVALID  = 1'b1;
    s_axi.BREADY  = 1'b1;
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!s_axi.AWREADY && n < 50);
    if (!s_axi.AWREADY) begin
      timeout_fail("awready");
      s_axi.AWVALID = 1'b0;
      s_axi.WVALID  = 1'b0;
      return;
    end
    @(posedge ACLK);
    #1;
    s_axi.AWVALID = 1'b0;
    s_axi.WVALID  = 1'b0;
    n = 0;
    while (!s_axi.BVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (!s_axi.BVALID) begin
      timeout_fail("bvalid");
      return;
    end
    @(posedge ACLK);
    #1;
    $display("wr addr=%h data=%h strb=%h", addr, data, strb);
  endtask

  task automatic axi_read(input logic [6:0] addr, input logic [31:0] exp, input string nm);
    int  n;
    rd_t r;
    @(posedge ACLK);
    #1;
    s_axi.ARADDR  = addr;
    s_axi.ARVALID = 1'b1;
    r.name = nm;
    r.data = exp;
    rd_q.push_back(r);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (!s_axi.ARREADY && n < 50);
    if (!s_axi.ARREADY) begin
      timeout_fail("arready");
      s_axi.ARVALID = 1'b0;
      rd_q.delete();
      return;
    end
    @(posedge ACLK);
    #1;
    s_axi.ARVALID = 1'b0;
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN       = 1'b0;
    s_axi.AWADDR  = '0;
    s_axi.AWVALID = 1'b0;
    s_axi.WDATA   = '0;
    s_axi.WSTRB   = '0;
    s_axi.WVALID  = 1'b0;
    s_axi.BREADY  = 1'b0;
    s_axi.ARADDR  = '0;
    s_axi.ARVALID = 1'b0;
    s_axi.RREADY  = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;

    // Reset state
    push_cyc("reset_hs", 1, 4'h0, 4'h0);
    push_cyc("reset_out", 0, 4'h0, 4'h0);
    push_cyc("reset_out", 0, 4'h0, 4'h0);
    drain();
    axi_read(7'h00, 32'h0, "rst_ctrl");
    axi_read(7'h04, 32'h0, "rst_status");
    axi_read(7'h20, 32'h1, "rst_period0");
    axi_read(7'h24, 32'h1, "rst_high0");

    // Divide by 10, 3 high cycles; first tick one cycle after the handshake
    axi_write(7'h20, 32'd9, 4'hF);
    axi_write(7'h24, 32'd3, 4'hF);
    axi_write(7'h00, 32'h1, 4'hF);
    push_wave("div10", 20, 9, 3, 4'b0001);
    drain();
    axi_read(7'h04, 32'h1, "status_on");
    axi_read(7'h20, 32'd9, "period0_rb");

    // Disable forces outputs low
    axi_write(7'h00, 32'h0, 4'hF);
    push_wave("disable", 3, 9, 0, 4'b0000);
    drain();

    // Period change mid-period: current 10-cycle period completes, then 5
    axi_write(7'h00, 32'h1, 4'hF);
    for (int k = 0; k < 25; k++) begin
      int j;
      j = (k < 10) ? k : (k - 10) % 5;
      push_cyc("period_change", 0, (j < 3) ? 4'b0001 : 4'b0000, (j == 0) ? 4'b0001 : 4'b0000);
    end
    axi_write(7'h20, 32'd4, 4'hF);
    drain();
    axi_write(7'h00, 32'h0, 4'hF);

    // Channel 1 boundaries: HIGH=0, HIGH>PERIOD, PERIOD=0
    axi_write(7'h28, 32'd9, 4'hF);
    axi_write(7'h2C, 32'd0, 4'hF);
    axi_write(7'h00, 32'h2, 4'hF);
    push_wave("high_zero", 12, 9, 0, 4'b0010);
    drain();
    axi_write(7'h00, 32'h0, 4'hF);
    axi_write(7'h2C, 32'd20, 4'hF);
    axi_write(7'h00, 32'h2, 4'hF);
    push_wave("high_gt_period", 12, 9, 20, 4'b0010);
    drain();
    axi_write(7'h00, 32'h0, 4'hF);
    axi_write(7'h28, 32'd0, 4'hF);
    axi_write(7'h2C, 32'd1, 4'hF);
    axi_write(7'h00, 32'h2, 4'hF);
    push_wave("period_zero", 8, 0, 1, 4'b0010);
    drain();
    axi_write(7'h00, 32'h0, 4'hF);

    // SYNC: channels 0 and 2 started 7 cycles apart, then phase-aligned
    axi_write(7'h20, 32'd7, 4'hF);
    axi_write(7'h24, 32'd4, 4'hF);
    axi_write(7'h30, 32'd7, 4'hF);
    axi_write(7'h34, 32'd4, 4'hF);
    axi_write(7'h00, 32'h1, 4'hF);
    repeat (3) @(posedge ACLK);
    axi_write(7'h00, 32'h5, 4'hF);
    repeat (5) @(posedge ACLK);
    axi_write(7'h08, 32'h5, 4'hF);
    push_wave("sync", 16, 7, 4, 4'b0101);
    drain();
    axi_read(7'h08, 32'h0, "sync_reads_zero");

    // Handshake: AW alone is not accepted, BVALID holds while BREADY is low
    @(posedge ACLK);
    #1;
    s_axi.AWADDR  = 7'h20;
    s_axi.AWVALID = 1'b1;
    s_axi.WVALID  = 1'b0;
    s_axi.BREADY  = 1'b0;
    s_axi.WDATA   = 32'h0000_1234;
    s_axi.WSTRB   = 4'hF;
    push_cyc("aw_only", 1, 4'b0000, 4'h0);
    push_cyc("aw_only", 1, 4'b0000, 4'h0);
    push_cyc("aw_only", 1, 4'b0000, 4'h0);
    drain();
    s_axi.WVALID = 1'b1;
    push_cyc("aw_w_wait", 1, 4'b0000, 4'h0);
    push_cyc("aw_w_accept", 1, 4'b0110, 4'h0);
    for (int k = 0; k < 5; k++) push_cyc("bvalid_hold", 1, 4'b0001, 4'h0);
    @(posedge ACLK);
    @(posedge ACLK);
    #1;
    s_axi.AWVALID = 1'b0;
    s_axi.WVALID  = 1'b0;
    drain();
    s_axi.BREADY = 1'b1;
    push_cyc("bvalid_last", 1, 4'b0001, 4'h0);
    push_cyc("bvalid_clear", 1, 4'b0000, 4'h0);
    drain();
    $display("wr addr=20 data=00001234 strb=f (manual handshake)");
    axi_read(7'h20, 32'h0000_1234, "manual_write");

    // Byte strobes, bits above the counter width, unmapped accesses
    axi_write(7'h20, 32'hFFFF_FF5A, 4'h1);
    axi_read(7'h20, 32'h0000_125A, "wstrb_byte0");
    axi_write(7'h24, 32'h00AB_0000, 4'h4);
    axi_read(7'h24, 32'h0000_0004, "upper_bits_zero");
    axi_read(7'h7C, 32'h0, "unmapped_7c");
    axi_read(7'h48, 32'h0, "ch5_period_zero");
    axi_write(7'h60, 32'hFFFF_FFFF, 4'hF);
    axi_read(7'h00, 32'h5, "ctrl_after_unmapped_wr");

    // Asynchronous reset mid-operation clears outputs before the next edge
    axi_write(7'h00, 32'h0, 4'hF);
    axi_write(7'h00, 32'h2, 4'hF);
    push_cyc("pre_reset", 0, 4'b0010, 4'b0010);
    drain();
    ARESETN = 1'b0;
    push_cyc("async_reset_out", 0, 4'h0, 4'h0);
    push_cyc("async_reset_hs", 1, 4'h0, 4'h0);
    drain();
    ARESETN = 1'b1;
    axi_read(7'h00, 32'h0, "ctrl_after_reset");
    axi_read(7'h20, 32'h1, "period0_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
